alu_shift_seq: RTL and testbench

//   Multi-cycle shift sequencer for the core ALU: accepts a shift request
//   (opcode, signed operand, shift amount) on a valid/ready handshake and

---
 rtl/alu_shift_seq_if.sv | 26 ++
 rtl/alu_shift_seq.sv | 81 ++++++++
 tb/tb_alu_shift_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_shift_seq_if.sv
// Request/response channel bundle for the multi-cycle shift sequencer.
interface alu_shift_seq_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic [3:0]              req_opcode;
  logic signed [WIDTH-1:0] req_a;
  logic [AMT_W-1:0]        req_amt;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic signed [WIDTH-1:0] rsp_data;
  logic                    rsp_err;
  logic                    busy;

  modport master (
    output req_valid, req_opcode, req_a, req_amt, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_amt, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/alu_shift_seq.sv
// Iterative 1-bit-per-cycle arithmetic shifter; response k cycles after accept (next cycle for k=0/illegal).
// Accepts only when idle; result is held in DONE until rsp_ready, further requests are not queued.
module alu_shift_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  alu_shift_seq_if.slave  bus
);
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SAR = 4'b0111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state, state_nxt;
  logic signed [WIDTH-1:0] acc, acc_nxt;
  logic [AMT_W-1:0]        cnt, cnt_nxt;
  logic                    err, err_nxt;
  logic                    shl, shl_nxt;
  logic                    op_legal;

  assign op_legal = (bus.req_opcode == OP_SHL) || (bus.req_opcode == OP_SAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      shl   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
      shl   <= shl_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    err_nxt   = err;
    shl_nxt   = shl;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          shl_nxt = (bus.req_opcode == OP_SHL);
          cnt_nxt = bus.req_amt;
          if (!op_legal) begin
            acc_nxt   = '0;
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            acc_nxt   = bus.req_a;
            err_nxt   = 1'b0;
            state_nxt = (bus.req_amt == '0) ? DONE : SHIFT;
          end
        end
      end
      SHIFT: begin
        // Arithmetic shifts: left zero-fills and drops the MSB, right replicates the sign.
        acc_nxt = shl ? (acc <<< 1) : (acc >>> 1);
        cnt_nxt = cnt - 1'b1;
        if (cnt == {{(AMT_W-1){1'b0}}, 1'b1}) state_nxt = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_data  = acc;
  assign bus.rsp_err   = err;
endmodule

// File: tb/tb_alu_shift_seq.sv
// Scoreboarded bench for alu_shift_seq: directed shift requests, monitor checks latency, data and hold behaviour.
module tb_alu_shift_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          exp_cyc;
  } exp_t;

  exp_t q[$];

  alu_shift_seq_if #(.WIDTH(16), .AMT_W(4)) bus ();

  alu_shift_seq #(.WIDTH(16), .AMT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents a request and returns just before the accepting edge; lat is cycles to rsp_valid.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [3:0] amt,
                      input logic [15:0] exp_data, input logic exp_err, input int lat);
    int   g;
    exp_t e;
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_opcode = op;
    bus.req_a      = a;
    bus.req_amt    = amt;
    g = 0;
    while (!bus.req_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1");
    end
    e.data    = exp_data;
    e.err     = exp_err;
    e.exp_cyc = cyc + 1 + lat;
    q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    repeat (3) @(posedge clk);
  endtask

  // Monitor: latency on rsp_valid rise, data/err on handshake, stability while stalled.
  logic        prev_valid;
  logic        prev_hold;
  logic [15:0] prev_data;
  logic        prev_err;
  initial begin
    prev_valid = 1'b0;
    prev_hold  = 1'b0;
    prev_data  = '0;
    prev_err   = 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      if (bus.rsp_valid && !prev_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got data %h with no request outstanding", bus.rsp_data);
        end else if (cyc != q[0].exp_cyc) begin
          errors++;
          $display("FAIL rsp_latency: got cycle %0d expected %0d", cyc, q[0].exp_cyc);
        end
      end
      if (prev_hold && bus.rsp_valid) begin
        chk("hold_data", {16'h0, bus.rsp_data}, {16'h0, prev_data});
        chk("hold_err", {31'h0, bus.rsp_err}, {31'h0, prev_err});
        chk("hold_req_ready", {31'h0, bus.req_ready}, 32'h0);
      end
      if (bus.rsp_valid && bus.rsp_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("rsp_data", {16'h0, bus.rsp_data}, {16'h0, e.data});
        chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
      end
      prev_hold  = bus.rsp_valid && !bus.rsp_ready;
      prev_valid = bus.rsp_valid;
      prev_data  = bus.rsp_data;
      prev_err   = bus.rsp_err;
    end
  end

  initial begin
    int g;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_opcode = 4'h0;
    bus.req_a      = '0;
    bus.req_amt    = '0;
    bus.rsp_ready  = 1'b1;
    #1;
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_data", {16'h0, bus.rsp_data}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic left shift and directed boundary vectors
    send(4'b0110, 16'h0003, 4'd4,  16'h0030, 1'b0, 4);  idle(); wait_drain();
    send(4'b0111, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 15); idle(); wait_drain();
    send(4'b0111, 16'h7FFF, 4'd3,  16'h0FFF, 1'b0, 3);  idle(); wait_drain();
    send(4'b0110, 16'h4001, 4'd1,  16'h8002, 1'b0, 1);  idle(); wait_drain();
    send(4'b0110, 16'h8001, 4'd1,  16'h0002, 1'b0, 1);  idle(); wait_drain();
    send(4'b0111, 16'hFFF0, 4'd2,  16'hFFFC, 1'b0, 2);  idle(); wait_drain();
    send(4'b0111, 16'h0005, 4'd15, 16'h0000, 1'b0, 15); idle(); wait_drain();
    send(4'b0110, 16'h1234, 4'd0,  16'h1234, 1'b0, 0);  idle(); wait_drain();
    send(4'b0001, 16'h5555, 4'd3,  16'h0000, 1'b1, 0);  idle(); wait_drain();

    // Consumer stall in DONE with a stray request pulse
    bus.rsp_ready = 1'b0;
    send(4'b0110, 16'h0001, 4'd1, 16'h0002, 1'b0, 1);
    idle();
    g = 0;
    while (!bus.rsp_valid && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("stall_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.req_valid  = (i == 2);
      bus.req_opcode = 4'b0110;
      bus.req_a      = 16'h00FF;
      bus.req_amt    = 4'd0;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_drain();

    // Reset two shifts into an 8-step operation
    send(4'b0110, 16'h0001, 4'd8, 16'h0100, 1'b0, 8);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_shift_busy", {31'h0, bus.busy}, 32'h1);
    rst = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("mid_rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("mid_rst_rsp_data", {16'h0, bus.rsp_data}, 32'h0);
    chk("mid_rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    chk("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(4'b0110, 16'h0001, 4'd2, 16'h0004, 1'b0, 2); idle(); wait_drain();

    // Back-to-back with rsp_ready held high
    send(4'b0110, 16'h0003, 4'd2, 16'h000C, 1'b0, 2);
    send(4'b0111, 16'hABCD, 4'd0, 16'hABCD, 1'b0, 0);
    idle();
    wait_drain();
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
